mem_port_arbiter: RTL

Arbitrates the instruction-fetch port and the load/store data port of the core onto the single byte-addressed SRAM port (MemRead, MemWrite[3:0], address, write_data, read_data). Grants at most one access per cycle, with data priority and a starvation guard for fetch. Generates byte-lane write enables from access size, and returns registered, size-formatted (sign/zero-extended) read data one cycle after grant.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_load_fmt.sv | 23 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared size encodings, starve-counter width and byte-lane enable lookup
// for the SRAM port arbiter.
package mem_arb_pkg;

    localparam int STARVE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    // Lanes are LSB-aligned: lane k writes address+k.
    function automatic logic [3:0] byte_en(input logic [1:0] size);
        case (size)
            SZ_BYTE: byte_en = 4'b0001;
            SZ_HALF: byte_en = 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Combinational load formatter: selects byte/half/word from SRAM read data
// and sign- or zero-extends it to 32 bits.
module mem_load_fmt
    import mem_arb_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] result
);

    always_comb begin
        result = read_data;
        case (size)
            SZ_BYTE: result = zext ? {24'h0, read_data[7:0]}
                                   : {{24{read_data[7]}}, read_data[7:0]};
            SZ_HALF: result = zext ? {16'h0, read_data[15:0]}
                                   : {{16{read_data[15]}}, read_data[15:0]};
            default: result = read_data;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one SRAM port: data priority,
// fetch starvation guard, registered formatted responses one cycle after grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        MemRead,
    output logic [3:0]  MemWrite,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam logic [STARVE_W-1:0] LIMIT   = STARVE_W'(STARVE_LIMIT);
    localparam logic [31:0]         HI_MASK = ~((32'h1 << ADDR_W) - 32'h1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                fetch_win;
    logic                illegal;
    logic                d_load_ok;
    logic [31:0]         fmt_dat;

    // Fetch wins when alone or once it has lost STARVE_LIMIT contested cycles.
    assign fetch_win = if_req && (!d_req || starve_cnt == LIMIT);
    assign if_gnt    = rst_n && fetch_win;
    assign d_gnt     = rst_n && d_req && !fetch_win;
    assign illegal   = (d_size == SZ_ILL) || ((d_addr & HI_MASK) != 32'h0);
    assign d_load_ok = d_gnt && !illegal && !d_we;

    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 4'b0000;
        address    = 32'h0;
        write_data = 32'h0;
        if (if_gnt) begin
            MemRead = 1'b1;
            address = if_addr;
        end else if (d_gnt) begin
            address = d_addr;
            if (!illegal) begin
                if (d_we) begin
                    MemWrite   = byte_en(d_size);
                    write_data = d_wdata;
                end else begin
                    MemRead = 1'b1;
                end
            end
        end
    end

    mem_load_fmt u_load_fmt (
        .read_data (read_data),
        .size      (d_size),
        .zext      (d_unsigned),
        .result    (fmt_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            d_err      <= 1'b0;
            if_rdata   <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            if (if_gnt || !if_req)
                starve_cnt <= '0;
            else if (d_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
            if_rvalid <= if_gnt;
            d_rvalid  <= d_load_ok;
            d_err     <= d_gnt && illegal;
            if (if_gnt)
                if_rdata <= read_data;
            if (d_load_ok)
                d_rdata <= fmt_dat;
        end
    end

endmodule
